// File: rtl/synapse_multi_if.sv
// Spike, configuration-chain and synaptic-current signals of synapse_multi.
// master = stimulus side, slave = the synapse block.
interface synapse_multi_if #(
   parameter int WORD_LENGTH = 16
);
   logic                   spike_valid;
   logic [7:0]             spike_address;
   logic                   spike_on_off;
   logic                   cfg_shift;
   logic [WORD_LENGTH-1:0] cfg_in;
   logic [WORD_LENGTH-1:0] cfg_out;
   logic [WORD_LENGTH-1:0] E_rev;
   logic [WORD_LENGTH-1:0] vmem;
   logic [WORD_LENGTH-1:0] output_current;
   logic                   out_valid;

   modport master (
      output spike_valid, spike_address, spike_on_off, cfg_shift, cfg_in, E_rev, vmem,
      input  cfg_out, output_current, out_valid
   );

   modport slave (
      input  spike_valid, spike_address, spike_on_off, cfg_shift, cfg_in, E_rev, vmem,
      output cfg_out, output_current, out_valid
   );
endinterface

// File: rtl/synapse_multi.sv
// Multi-channel conductance synapse: shift-chain config, saturating gsyn per channel and a
// time-multiplexed current engine. Optional gsyn decay is enabled by defining SYN_DECAY_EN.
module synapse_multi #(
   parameter int                     NUM_CH       = 4,
   parameter int                     WORD_LENGTH  = 16,
   parameter logic [WORD_LENGTH-1:0] GSYN_MAX     = 16'hFFFF,
   parameter int                     RSHIFT       = 9,
   parameter int                     DECAY_PERIOD = 64
) (
   input logic            clk,
   input logic            reset,
   synapse_multi_if.slave bus
);
   localparam int KW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int DW    = WORD_LENGTH + 1;
   localparam int PW    = 2 * WORD_LENGTH + 2;
   localparam int ACC_W = PW + KW;
   localparam int NCFG  = 2 * NUM_CH;
   localparam logic [KW-1:0] K_LAST = KW'(NUM_CH - 1);

   typedef enum logic {ACCUM = 1'b0, PUBLISH = 1'b1} state_e;

   if (DECAY_PERIOD < 1) begin : g_bad_decay_period
      $error("synapse_multi: DECAY_PERIOD must be at least 1");
   end

   function automatic logic [WORD_LENGTH-1:0] gsyn_inc(input logic [WORD_LENGTH-1:0] g,
                                                      input logic [WORD_LENGTH-1:0] w);
      logic [WORD_LENGTH:0] sum;
      sum = {1'b0, g} + {1'b0, w};
      if (sum > {1'b0, GSYN_MAX}) return GSYN_MAX;
      else return sum[WORD_LENGTH-1:0];
   endfunction

   function automatic logic [WORD_LENGTH-1:0] gsyn_dec(input logic [WORD_LENGTH-1:0] g,
                                                      input logic [WORD_LENGTH-1:0] w);
      if (g > w) return g - w;
      else return {WORD_LENGTH{1'b0}};
   endfunction

   function automatic logic [WORD_LENGTH-1:0] sat_word(input logic signed [ACC_W-1:0] v);
      if ((&v[ACC_W-1:WORD_LENGTH-1]) || !(|v[ACC_W-1:WORD_LENGTH-1])) return v[WORD_LENGTH-1:0];
      else if (v[ACC_W-1]) return {1'b1, {(WORD_LENGTH-1){1'b0}}};
      else return {1'b0, {(WORD_LENGTH-1){1'b1}}};
   endfunction

   logic [WORD_LENGTH-1:0]    chain_q [NCFG];
   logic [WORD_LENGTH-1:0]    chain_d [NCFG];
   logic [WORD_LENGTH-1:0]    cfg_out_q, cfg_out_d;
   logic [WORD_LENGTH-1:0]    gsyn_q [NUM_CH];
   logic [WORD_LENGTH-1:0]    gsyn_d [NUM_CH];
   logic [WORD_LENGTH-1:0]    gsyn_base_s [NUM_CH];
   state_e                    state_q, state_d;
   logic [KW-1:0]             k_q, k_d;
   logic signed [DW-1:0]      diff_q, diff_d;
   logic signed [DW-1:0]      diff_fresh_s, diff_use_s;
   logic signed [PW-1:0]      prod_s;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic signed [ACC_W-1:0]   acc_shift_s;
   logic [WORD_LENGTH-1:0]    cur_q, cur_d;
   logic                      valid_q, valid_d;
   logic [WORD_LENGTH-1:0]    gsyn_sel_s;

`ifdef SYN_DECAY_EN
   localparam int DCW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
   localparam logic [DCW-1:0] DECAY_LAST = DCW'(DECAY_PERIOD - 1);
   logic [DCW-1:0] decay_cnt_q, decay_cnt_d;
   logic           decay_tick_s;

   assign decay_tick_s = (decay_cnt_q == DECAY_LAST);

   // Free-running decay timer, wraps every DECAY_PERIOD cycles.
   always_comb begin
      if (decay_tick_s) decay_cnt_d = {DCW{1'b0}};
      else decay_cnt_d = decay_cnt_q + DCW'(1);
   end

   // Decay timer register.
   always_ff @(posedge clk) begin
      if (reset) decay_cnt_q <= {DCW{1'b0}};
      else decay_cnt_q <= decay_cnt_d;
   end
`endif

   // Config chain shift; matching below still sees the pre-shift chain_q.
   always_comb begin
      chain_d   = chain_q;
      cfg_out_d = cfg_out_q;
      if (bus.cfg_shift) begin
         chain_d[0] = bus.cfg_in;
         for (int j = 1; j < NCFG; j++) chain_d[j] = chain_q[j-1];
         cfg_out_d = chain_q[NCFG-1];
      end else begin
         cfg_out_d = cfg_out_q;
      end
   end

   // Per-channel conductance update; several channels may share one address.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef SYN_DECAY_EN
         if (decay_tick_s && (gsyn_q[i] != {WORD_LENGTH{1'b0}}))
            gsyn_base_s[i] = gsyn_q[i] - {{(WORD_LENGTH-1){1'b0}}, 1'b1};
         else
            gsyn_base_s[i] = gsyn_q[i];
`else
         gsyn_base_s[i] = gsyn_q[i];
`endif
         if (bus.spike_valid && (bus.spike_address == chain_q[2*i+1][7:0])) begin
            if (bus.spike_on_off) gsyn_d[i] = gsyn_inc(gsyn_base_s[i], chain_q[2*i]);
            else gsyn_d[i] = gsyn_dec(gsyn_base_s[i], chain_q[2*i]);
         end else begin
            gsyn_d[i] = gsyn_base_s[i];
         end
      end
   end

   assign diff_fresh_s = $signed({bus.E_rev[WORD_LENGTH-1], bus.E_rev})
                       - $signed({bus.vmem[WORD_LENGTH-1], bus.vmem});
   assign diff_use_s   = (k_q == {KW{1'b0}}) ? diff_fresh_s : diff_q;
   assign gsyn_sel_s   = gsyn_q[k_q];
   assign prod_s       = $signed({{(PW-DW){diff_use_s[DW-1]}}, diff_use_s})
                       * $signed({{(PW-WORD_LENGTH){1'b0}}, gsyn_sel_s});
   assign acc_shift_s  = acc_q >>> RSHIFT;

   // Current engine: NUM_CH accumulate cycles, then one publish cycle.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      diff_d  = diff_q;
      acc_d   = acc_q;
      cur_d   = cur_q;
      valid_d = 1'b0;
      case (state_q)
         ACCUM: begin
            diff_d = diff_use_s;
            acc_d  = acc_q + {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};
            if (k_q == K_LAST) begin
               state_d = PUBLISH;
               k_d     = {KW{1'b0}};
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         PUBLISH: begin
            cur_d   = sat_word(acc_shift_s);
            valid_d = 1'b1;
            acc_d   = {ACC_W{1'b0}};
            state_d = ACCUM;
            k_d     = {KW{1'b0}};
         end
         default: begin
            state_d = ACCUM;
            k_d     = {KW{1'b0}};
            acc_d   = {ACC_W{1'b0}};
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         chain_q   <= '{default: {WORD_LENGTH{1'b0}}};
         gsyn_q    <= '{default: {WORD_LENGTH{1'b0}}};
         cfg_out_q <= {WORD_LENGTH{1'b0}};
         state_q   <= ACCUM;
         k_q       <= {KW{1'b0}};
         diff_q    <= {DW{1'b0}};
         acc_q     <= {ACC_W{1'b0}};
         cur_q     <= {WORD_LENGTH{1'b0}};
         valid_q   <= 1'b0;
      end else begin
         chain_q   <= chain_d;
         gsyn_q    <= gsyn_d;
         cfg_out_q <= cfg_out_d;
         state_q   <= state_d;
         k_q       <= k_d;
         diff_q    <= diff_d;
         acc_q     <= acc_d;
         cur_q     <= cur_d;
         valid_q   <= valid_d;
      end
   end

   assign bus.cfg_out        = cfg_out_q;
   assign bus.output_current = cur_q;
   assign bus.out_valid      = valid_q;
endmodule

// File: tb/tb_synapse_multi.sv
// Self-checking bench for synapse_multi: vector tables, directed corner sequences and a
// randomized run against a frame-level reference model.
module tb_synapse_multi;
   localparam int NCH  = 4;
   localparam int NCFG = 8;

   typedef struct {
      logic [15:0] din;
      logic [15:0] dout;
   } cfg_vec_t;

   typedef struct {
      logic [15:0] e_rev;
      logic [15:0] vmem;
      longint      exp_cur;
   } cur_vec_t;

   logic clk;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [15:0] cfg_img [NCFG];
   cfg_vec_t    cfg_tbl [16];
   cur_vec_t    cur_tbl [8];

   // reference model state
   longint      m_g [NCH];
   logic [15:0] m_cfg [NCFG];
   logic [15:0] m_cfg_out;
   longint      m_diff;
   longint      m_acc;
   int          m_pos;

   synapse_multi_if #(.WORD_LENGTH(16)) sif ();
   synapse_multi_if #(.WORD_LENGTH(16)) mif ();

   synapse_multi #(.NUM_CH(4), .WORD_LENGTH(16), .GSYN_MAX(16'hFFFF), .RSHIFT(9), .DECAY_PERIOD(64))
      u_dut (.clk(clk), .reset(reset), .bus(sif));

   synapse_multi #(.NUM_CH(4), .WORD_LENGTH(16), .GSYN_MAX(16'd1000), .RSHIFT(9), .DECAY_PERIOD(64))
      u_dut_max (.clk(clk), .reset(reset), .bus(mif));

   assign mif.spike_valid   = sif.spike_valid;
   assign mif.spike_address = sif.spike_address;
   assign mif.spike_on_off  = sif.spike_on_off;
   assign mif.cfg_shift     = sif.cfg_shift;
   assign mif.cfg_in        = sif.cfg_in;
   assign mif.E_rev         = sif.E_rev;
   assign mif.vmem          = sif.vmem;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint sat16(input longint v);
      if (v > 32767) return 32767;
      else if (v < -32768) return -32768;
      else return v;
   endfunction

   task automatic do_reset();
      reset             = 1'b1;
      sif.spike_valid   = 1'b0;
      sif.spike_address = 8'd0;
      sif.spike_on_off  = 1'b0;
      sif.cfg_shift     = 1'b0;
      sif.cfg_in        = 16'd0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_cfg(input logic [15:0] w0, input logic [15:0] a0,
                          input logic [15:0] wo, input logic [15:0] ao);
      cfg_img[0] = w0;
      cfg_img[1] = a0;
      for (int c = 1; c < NCH; c++) begin
         cfg_img[2*c]   = wo;
         cfg_img[2*c+1] = ao;
      end
      // first word shifted in travels to the far end of the chain
      sif.cfg_shift = 1'b1;
      for (int j = NCFG - 1; j >= 0; j--) begin
         sif.cfg_in = cfg_img[j];
         tick();
      end
      sif.cfg_shift = 1'b0;
   endtask

   task automatic spike(input logic [7:0] addr, input logic on);
      sif.spike_valid   = 1'b1;
      sif.spike_address = addr;
      sif.spike_on_off  = on;
      tick();
      sif.spike_valid   = 1'b0;
   endtask

   task automatic wait_valid(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!sif.out_valid && cycles < 20);
      if (!sif.out_valid) begin
         n_cmp++;
         n_err++;
         $display("FAIL valid_timeout: no out_valid within %0d cycles, required one", cycles);
      end
   endtask

   // One cycle of the reference: frame position m_pos 0..NCH-1 sums, NCH publishes.
   task automatic model_step(output logic exp_valid, output longint exp_cur);
      logic [15:0] old_last;
      exp_valid = 1'b0;
      exp_cur   = 0;
      if (m_pos == 0) m_diff = longint'($signed(sif.E_rev)) - longint'($signed(sif.vmem));
      if (m_pos < NCH) begin
         m_acc = m_acc + m_diff * m_g[m_pos];
      end else begin
         exp_valid = 1'b1;
         exp_cur   = sat16(m_acc >>> 9);
         m_acc     = 0;
      end
      for (int c = 0; c < NCH; c++) begin
         if (sif.spike_valid && sif.spike_address == m_cfg[2*c+1][7:0]) begin
            if (sif.spike_on_off) m_g[c] = (m_g[c] + m_cfg[2*c] > 65535) ? 65535 : m_g[c] + m_cfg[2*c];
            else m_g[c] = (m_g[c] > m_cfg[2*c]) ? m_g[c] - m_cfg[2*c] : 0;
         end
      end
      if (sif.cfg_shift) begin
         old_last = m_cfg[NCFG-1];
         for (int j = NCFG - 1; j > 0; j--) m_cfg[j] = m_cfg[j-1];
         m_cfg[0]  = sif.cfg_in;
         m_cfg_out = old_last;
      end
      m_pos = (m_pos == NCH) ? 0 : m_pos + 1;
   endtask

   initial begin
      int          cyc;
      logic        ev;
      longint      ec;

      for (int i = 0; i < 16; i++) begin
         cfg_tbl[i].din  = 16'(i + 1);
         cfg_tbl[i].dout = (i < 8) ? 16'd0 : 16'(i - 7);
      end
      // gsyn[0]=512 makes the published current equal diff, saturated
      cur_tbl[0] = '{16'sd1000,   -16'sd24,    1024};
      cur_tbl[1] = '{-16'sd1000,  16'sd24,     -1024};
      cur_tbl[2] = '{16'sd100,    -16'sd100,   200};
      cur_tbl[3] = '{-16'sd1,     16'sd0,      -1};
      cur_tbl[4] = '{16'sd0,      16'sd0,      0};
      cur_tbl[5] = '{16'sd32767,  -16'sd32768, 32767};
      cur_tbl[6] = '{-16'sd32768, 16'sd32767,  -32768};
      cur_tbl[7] = '{16'sd20000,  -16'sd20000, 32767};

      sif.E_rev = 16'd0;
      sif.vmem  = 16'd0;
      do_reset();
      reset = 1'b1;
      tick();
      check("rst_current", longint'(sif.output_current), 0);
      check("rst_valid", longint'(sif.out_valid), 0);
      check("rst_cfg_out", longint'(sif.cfg_out), 0);
      check("rst_gsyn0", longint'(u_dut.gsyn_q[0]), 0);
      reset = 1'b0;

      // config chain pass-through
      sif.cfg_shift = 1'b1;
      for (int i = 0; i < 16; i++) begin
         sif.cfg_in = cfg_tbl[i].din;
         tick();
         check("cfg_out_seq", longint'(sif.cfg_out), longint'(cfg_tbl[i].dout));
         if (i == 7) begin
            check("cfg_addr3", longint'(u_dut.chain_q[7]), 1);
            check("cfg_weight3", longint'(u_dut.chain_q[6]), 2);
            check("cfg_weight0", longint'(u_dut.chain_q[0]), 8);
         end
      end
      sif.cfg_shift = 1'b0;

      // on spikes accumulate, off spikes floor at zero
      do_reset();
      set_cfg(16'd100, 16'd5, 16'd0, 16'hFF);
      for (int n = 1; n <= 3; n++) begin
         spike(8'd5, 1'b1);
         check("gsyn_on", longint'(u_dut.gsyn_q[0]), 100 * n);
      end
      spike(8'd6, 1'b1);
      check("gsyn_nomatch", longint'(u_dut.gsyn_q[0]), 300);
      for (int n = 1; n <= 4; n++) begin
         spike(8'd5, 1'b0);
         check("gsyn_off", longint'(u_dut.gsyn_q[0]), (300 - 100 * n > 0) ? 300 - 100 * n : 0);
      end

      // ceiling at GSYN_MAX=1000 on the second instance
      do_reset();
      set_cfg(16'd300, 16'd5, 16'd0, 16'hFF);
      for (int n = 1; n <= 4; n++) begin
         spike(8'd5, 1'b1);
         check("gsyn_ceiling", longint'(u_dut_max.gsyn_q[0]), (300 * n > 1000) ? 1000 : 300 * n);
      end
      check("gsyn_noceil", longint'(u_dut.gsyn_q[0]), 1200);

      // current table with gsyn[0]=512
      do_reset();
      set_cfg(16'd512, 16'd5, 16'd0, 16'hFF);
      spike(8'd5, 1'b1);
      for (int v = 0; v < 8; v++) begin
         sif.E_rev = cur_tbl[v].e_rev;
         sif.vmem  = cur_tbl[v].vmem;
         wait_valid(cyc);
         wait_valid(cyc);
         check("valid_period", cyc, 5);
         check("current_tbl", longint'($signed(sif.output_current)), cur_tbl[v].exp_cur);
      end

      // all channels at full conductance
      do_reset();
      set_cfg(16'hFFFF, 16'd7, 16'hFFFF, 16'd7);
      spike(8'd7, 1'b1);
      check("gsyn3_full", longint'(u_dut.gsyn_q[3]), 65535);
      sif.E_rev = 16'sd32767;
      sif.vmem  = -16'sd32768;
      wait_valid(cyc);
      wait_valid(cyc);
      check("current_sat_pos", longint'($signed(sif.output_current)), 32767);
      sif.E_rev = -16'sd32768;
      sif.vmem  = 16'sd32767;
      wait_valid(cyc);
      wait_valid(cyc);
      check("current_sat_neg", longint'($signed(sif.output_current)), -32768);

      // reset while at k=2 abandons the frame
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("midrst_current", longint'(sif.output_current), 0);
      check("midrst_valid", longint'(sif.out_valid), 0);
      check("midrst_gsyn0", longint'(u_dut.gsyn_q[0]), 0);
      reset = 1'b0;
      wait_valid(cyc);
      check("midrst_first_valid", cyc, 5);
      check("midrst_current_after", longint'(sif.output_current), 0);

      // randomized run against the reference model
      do_reset();
      for (int c = 0; c < NCH; c++) m_g[c] = 0;
      for (int j = 0; j < NCFG; j++) m_cfg[j] = 16'd0;
      m_cfg_out = 16'd0;
      m_acc     = 0;
      m_diff    = 0;
      m_pos     = 0;
      for (int t = 0; t < 600; t++) begin
         sif.spike_valid   = ($urandom_range(0, 1) == 1);
         sif.spike_address = 8'($urandom_range(0, 3));
         sif.spike_on_off  = ($urandom_range(0, 9) < 6);
         sif.cfg_shift     = ($urandom_range(0, 3) == 0);
         sif.cfg_in        = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         sif.E_rev         = 16'($urandom);
         sif.vmem          = 16'($urandom);
         model_step(ev, ec);
         tick();
         check("rnd_valid", longint'(sif.out_valid), longint'(ev));
         if (ev) check("rnd_current", longint'($signed(sif.output_current)), ec);
         check("rnd_cfg_out", longint'(sif.cfg_out), longint'(m_cfg_out));
      end
      for (int c = 0; c < NCH; c++) check("rnd_gsyn_final", longint'(u_dut.gsyn_q[c]), m_g[c]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
